// File: rtl/alu_mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiply controller for the execute stage.
// Sequences MUL (unsigned, low word) and MLS (signed, high word), then issues one Rd write-back.
module alu_mul_sequencer #(
    parameter int         WIDTH  = 16,
    parameter logic [5:0] OP_MUL = 6'b100001,
    parameter logic [5:0] OP_MLS = 6'b100010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       decoder_encoded_opcode,
    input  logic [WIDTH-1:0] rddata,
    input  logic [WIDTH-1:0] rs1data,
    input  logic             flush,
    input  logic [7:0]       statusregin,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             wenout,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       statusregout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 negate_q, negate_d;
    logic                 is_mls_q, is_mls_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     wb_result_q, wb_result_d;
    logic                 wb_carry_q, wb_carry_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 op_is_mul;
    logic                 op_is_mls;
    logic                 accept;
    logic [WIDTH:0]       iter_sum;
    logic [WIDTH:0]       iter_hi;
    logic [2*WIDTH-1:0]   signed_prod;
    logic                 flag_z;
    logic                 flag_n;
    logic                 flag_c;

    // Magnitude of a two's complement value; the most negative value maps to itself as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign op_is_mls = (decoder_encoded_opcode == OP_MLS);
    assign op_is_mul = (decoder_encoded_opcode == OP_MUL) || op_is_mls;
    assign accept    = start && (state_q == ST_IDLE) && op_is_mul;

    assign iter_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign iter_hi     = mplier_q[0] ? iter_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign signed_prod = negate_q ? -acc_q : acc_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        negate_d    = negate_q;
        is_mls_d    = is_mls_q;
        done_d      = 1'b0;
        wb_result_d = wb_result_q;
        wb_carry_d  = wb_carry_q;
        result_d    = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_mls_d = op_is_mls;
                    mcand_d  = op_is_mls ? magnitude(rddata) : rddata;
                    mplier_d = op_is_mls ? magnitude(rs1data) : rs1data;
                    negate_d = op_is_mls && (rddata[WIDTH-1] ^ rs1data[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = ST_ITER;
                end
            end
            ST_ITER: begin
                // Shift {carry, acc, multiplier} right; after WIDTH steps acc holds the full product.
                acc_d    = {iter_hi, acc_q[WIDTH-1:1]};
                mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_LAST) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                acc_d       = signed_prod;
                wb_result_d = is_mls_q ? signed_prod[2*WIDTH-1:WIDTH] : signed_prod[WIDTH-1:0];
                wb_carry_d  = (signed_prod[2*WIDTH-1:WIDTH] != '0);
                done_d      = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                result_d = wb_result_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abort drops whatever is in flight, including a pending write-back.
        if (flush && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            negate_q    <= 1'b0;
            is_mls_q    <= 1'b0;
            done_q      <= 1'b0;
            wb_result_q <= '0;
            wb_carry_q  <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            negate_q    <= negate_d;
            is_mls_q    <= is_mls_d;
            done_q      <= done_d;
            wb_result_q <= wb_result_d;
            wb_carry_q  <= wb_carry_d;
            result_q    <= result_d;
        end
    end

    // A flush arriving in DONE must still suppress that cycle's write-back.
    assign busy   = (state_q != ST_IDLE);
    assign stall  = busy || accept;
    assign done   = done_q && !flush;
    assign wenout = done;
    assign result = done ? wb_result_q : result_q;

    assign flag_z = (wb_result_q == '0);
    assign flag_n = wb_result_q[WIDTH-1];
    assign flag_c = is_mls_q ? statusregin[2] : wb_carry_q;

    assign statusregout = done ? {statusregin[7:3], flag_c, flag_n, flag_z} : statusregin;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed corner cases plus random MUL/MLS
// operations compared against an arithmetic reference model.
module tb_alu_mul_sequencer;

    localparam logic [5:0] OP_MUL = 6'b100001;
    localparam logic [5:0] OP_MLS = 6'b100010;
    localparam logic [5:0] OP_ADD = 6'b010001;
    localparam int         LATENCY = 18;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  opc;
    logic [15:0] rddata;
    logic [15:0] rs1data;
    logic        flush;
    logic [7:0]  sr_in;
    logic        busy;
    logic        stall;
    logic        done;
    logic        wenout;
    logic [15:0] result;
    logic [7:0]  statusregout;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] last_result;

    alu_mul_sequencer dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .decoder_encoded_opcode (opc),
        .rddata                 (rddata),
        .rs1data                (rs1data),
        .flush                  (flush),
        .statusregin            (sr_in),
        .busy                   (busy),
        .stall                  (stall),
        .done                   (done),
        .wenout                 (wenout),
        .result                 (result),
        .statusregout           (statusregout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiplication, then pick the word and flags.
    function automatic void modelOp(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [7:0] sr, output logic [15:0] res, output logic [7:0] st);
        logic [31:0] p;
        logic        c;
        int          sp;
        if (op == OP_MUL) begin
            p   = {16'h0000, a} * {16'h0000, b};
            res = p[15:0];
            c   = (p[31:16] != 16'h0000);
        end else begin
            sp  = int'($signed(a)) * int'($signed(b));
            p   = sp;
            res = p[31:16];
            c   = sr[2];
        end
        st = {sr[7:3], c, res[15], (res == 16'h0000)};
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one instruction for a single cycle; returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] sr, input logic expect_stall);
        start   = 1'b1;
        opc     = op;
        rddata  = a;
        rs1data = b;
        sr_in   = sr;
        #1;
        checkOutput("stall_on_start", {31'b0, stall}, {31'b0, expect_stall});
        waitCycles(1);
        start   = 1'b0;
        opc     = 6'($urandom);
        rddata  = 16'($urandom);
        rs1data = 16'($urandom);
    endtask

    task automatic finishOp(input int cyc_now, input logic [5:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [7:0] sr, input string tag);
        int          cyc;
        logic [15:0] exp_res;
        logic [7:0]  exp_st;
        cyc = cyc_now;
        while (done !== 1'b1 && cyc < 40) begin
            waitCycles(1);
            cyc++;
        end
        modelOp(op, a, b, sr, exp_res, exp_st);
        checkOutput($sformatf("%s_latency", tag), cyc, LATENCY);
        checkOutput($sformatf("%s_result", tag), {16'h0, result}, {16'h0, exp_res});
        checkOutput($sformatf("%s_status", tag), {24'h0, statusregout}, {24'h0, exp_st});
        checkOutput($sformatf("%s_wen", tag), {31'b0, wenout}, 32'd1);
        checkOutput($sformatf("%s_busy_done", tag), {31'b0, busy}, 32'd1);
        last_result = exp_res;
        waitCycles(1);
        checkOutput($sformatf("%s_idle_busy", tag), {31'b0, busy}, 32'd0);
        checkOutput($sformatf("%s_idle_done", tag), {31'b0, done}, 32'd0);
        checkOutput($sformatf("%s_hold", tag), {16'h0, result}, {16'h0, last_result});
        checkOutput($sformatf("%s_idle_status", tag), {24'h0, statusregout}, {24'h0, sr_in});
    endtask

    task automatic runOp(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] sr, input string tag);
        applyStimulus(op, a, b, sr, 1'b1);
        checkOutput($sformatf("%s_busy_c1", tag), {31'b0, busy}, 32'd1);
        finishOp(1, op, a, b, sr, tag);
    endtask

    initial begin
        logic       seen_done;
        logic [5:0] rop;
        reset       = 1'b1;
        start       = 1'b0;
        flush       = 1'b0;
        opc         = 6'h00;
        rddata      = 16'h0000;
        rs1data     = 16'h0000;
        sr_in       = 8'hA5;
        last_result = 16'h0000;
        waitCycles(2);
        reset = 1'b0;
        #1;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_wen", {31'b0, wenout}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_result", {16'h0, result}, 32'h0);
        checkOutput("rst_status", {24'h0, statusregout}, 32'hA5);

        runOp(OP_MUL, 16'h0003, 16'h0005, 8'h00, "mul_3x5");
        runOp(OP_MUL, 16'h1234, 16'h0100, 8'h00, "mul_ovf");
        runOp(OP_MUL, 16'hFFFF, 16'hFFFF, 8'hF8, "mul_max");
        runOp(OP_MLS, 16'hFFFE, 16'h0003, 8'h04, "mls_neg_c1");
        runOp(OP_MLS, 16'hFFFE, 16'h0003, 8'hFB, "mls_neg_c0");
        runOp(OP_MLS, 16'h8000, 16'h8000, 8'h00, "mls_min");
        runOp(OP_MLS, 16'hFFFF, 16'hFFFF, 8'h00, "mls_m1");
        runOp(OP_MUL, 16'h0000, 16'($urandom), 8'h04, "mul_zero");

        // Non-multiply opcode must not stall or start the sequencer.
        applyStimulus(OP_ADD, 16'h1111, 16'h2222, 8'h00, 1'b0);
        checkOutput("add_busy", {31'b0, busy}, 32'd0);
        waitCycles(2);
        checkOutput("add_busy_later", {31'b0, busy}, 32'd0);

        // Second start during ITER with different operands is ignored.
        applyStimulus(OP_MUL, 16'h1234, 16'h0003, 8'h00, 1'b1);
        waitCycles(4);
        start   = 1'b1;
        opc     = OP_MUL;
        rddata  = 16'hFFFF;
        rs1data = 16'hFFFF;
        #1;
        checkOutput("restart_stall", {31'b0, stall}, 32'd1);
        waitCycles(1);
        start = 1'b0;
        finishOp(6, OP_MUL, 16'h1234, 16'h0003, 8'h00, "ignore_restart");

        // Reset in cycle 10 aborts with no write-back.
        applyStimulus(OP_MUL, 16'h00FF, 16'h00FF, 8'h00, 1'b1);
        waitCycles(9);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        last_result = 16'h0000;
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_result", {16'h0, result}, 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen_done = seen_done | done | wenout;
            waitCycles(1);
        end
        checkOutput("midrst_no_done", {31'b0, seen_done}, 32'd0);
        runOp(OP_MUL, 16'h0007, 16'h0009, 8'h00, "post_rst");

        // Flush in the DONE cycle suppresses the write-back.
        applyStimulus(OP_MLS, 16'h0100, 16'hFF00, 8'h00, 1'b1);
        waitCycles(17);
        flush = 1'b1;
        #1;
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        checkOutput("flush_wen", {31'b0, wenout}, 32'd0);
        checkOutput("flush_result", {16'h0, result}, {16'h0, last_result});
        checkOutput("flush_status", {24'h0, statusregout}, {24'h0, sr_in});
        waitCycles(1);
        flush = 1'b0;
        checkOutput("flush_idle", {31'b0, busy}, 32'd0);
        checkOutput("flush_hold", {16'h0, result}, {16'h0, last_result});
        runOp(OP_MUL, 16'h0ABC, 16'h0010, 8'h00, "post_flush");

        // Flush during ITER, then flush held in IDLE does not block an accept.
        applyStimulus(OP_MUL, 16'h0101, 16'h0202, 8'h00, 1'b1);
        waitCycles(5);
        flush = 1'b1;
        waitCycles(1);
        checkOutput("flush_iter_idle", {31'b0, busy}, 32'd0);
        applyStimulus(OP_MUL, 16'h0022, 16'h0033, 8'h00, 1'b1);
        flush = 1'b0;
        finishOp(1, OP_MUL, 16'h0022, 16'h0033, 8'h00, "flush_in_idle");

        for (int i = 0; i < 30; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_MLS;
            runOp(rop, 16'($urandom), 16'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
